// File: rtl/pc_sequencer_pkg.sv
// Shared processor definitions: sequencer state type and default widths.
package proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DONE
  } seq_state_t;

  localparam int PC_W_DEF  = 10;
  localparam int OFF_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int START_PC  = 0;

endpackage

// File: rtl/pc_sequencer_if.sv
// Host/decoder/ProgCtr signal bundle for the run-control sequencer.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Halt;
  logic             StallReq;
  logic             BranchAbsEn;
  logic             BranchCondEn;
  logic             ALU_flag;
  logic [PC_W-1:0]  Target;
  logic [OFF_W-1:0] Offset;
  logic [PC_W-1:0]  ProgCtr_i;
  logic             PcReset;
  logic             PcStart;
  logic             PcBranch;
  logic [PC_W-1:0]  PcTarget;
  logic             Done;
  logic [CNT_W-1:0] CycleCnt;
  logic [CNT_W-1:0] InstrCnt;

  modport master (
    output Start, Halt, StallReq, BranchAbsEn, BranchCondEn, ALU_flag,
           Target, Offset, ProgCtr_i,
    input  PcReset, PcStart, PcBranch, PcTarget, Done, CycleCnt, InstrCnt
  );

  modport slave (
    input  Start, Halt, StallReq, BranchAbsEn, BranchCondEn, ALU_flag,
           Target, Offset, ProgCtr_i,
    output PcReset, PcStart, PcBranch, PcTarget, Done, CycleCnt, InstrCnt
  );
endinterface

// File: rtl/ProgCtr.sv
// Program counter: reset to zero, advance or load an absolute target when started.
module ProgCtr #(
  parameter int PC_W = 10
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            BranchAbsEn,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr
);
  logic [PC_W-1:0] r_pc;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc <= '0;
    end else if (Start) begin
      r_pc <= BranchAbsEn ? Target : r_pc + 1'b1;
    end
  end

  assign ProgCtr = r_pc;
endmodule

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/pc_sequencer.sv
// Run-control FSM driving ProgCtr, with branch-target adder and performance counters.
module pc_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int OFF_W    = OFF_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int START_PC = proc_pkg::START_PC
) (
  input logic           Clk,
  input logic           Reset,
  pc_sequencer_if.slave bus
);
  seq_state_t      r_state;
  seq_state_t      w_next;
  logic            r_start_q;
  logic            r_done;
  logic            w_start_rise;
  logic            w_pc_reset;
  logic            w_pc_start;
  logic            w_pc_branch;
  logic [PC_W-1:0] w_pc_target;
  logic [PC_W-1:0] w_rel_target;
  logic            w_clr;
  logic            w_cyc_en;
  logic            w_ins_en;

  assign w_start_rise = bus.Start & ~r_start_q;
  assign w_rel_target = bus.ProgCtr_i + PC_W'(signed'(bus.Offset));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_q <= bus.Start;
      r_done    <= (w_next == ST_DONE);
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pc_reset  = 1'b0;
    w_pc_start  = 1'b0;
    w_pc_branch = 1'b0;
    w_pc_target = bus.Target;
    w_clr       = 1'b0;
    w_cyc_en    = 1'b0;
    w_ins_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pc_reset = 1'b1;
        if (w_start_rise) w_next = ST_INIT;
      end
      ST_INIT: begin
        w_pc_start  = 1'b1;
        w_pc_branch = 1'b1;
        w_pc_target = PC_W'(START_PC);
        w_clr       = 1'b1;
        w_next      = ST_RUN;
      end
      ST_RUN: begin
        w_cyc_en = 1'b1;
        // Stall masks halt and branches entirely; otherwise the instruction retires.
        if (!bus.StallReq) begin
          w_ins_en = 1'b1;
          if (bus.Halt) begin
            w_next = ST_DONE;
          end else if (bus.BranchAbsEn) begin
            w_pc_start  = 1'b1;
            w_pc_branch = 1'b1;
          end else if (bus.BranchCondEn && bus.ALU_flag) begin
            w_pc_start  = 1'b1;
            w_pc_branch = 1'b1;
            w_pc_target = w_rel_target;
          end else begin
            w_pc_start = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (w_start_rise) w_next = ST_INIT;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_clr   (w_clr),
    .i_en    (w_cyc_en),
    .o_count (bus.CycleCnt)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_clr   (w_clr),
    .i_en    (w_ins_en),
    .o_count (bus.InstrCnt)
  );

  assign bus.PcReset  = w_pc_reset;
  assign bus.PcStart  = w_pc_start;
  assign bus.PcBranch = w_pc_branch;
  assign bus.PcTarget = w_pc_target;
  assign bus.Done     = r_done;
endmodule
